// File: rtl/reg_bus_master_ctrl_if.sv
// Command, response and register-bus signal bundle for reg_bus_master_ctrl.
// The master modport is the controller's view; slave is the view of the
// agent that issues commands and models the bus responder.
interface reg_bus_master_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int TMO_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] cmd_mask;
  logic [TMO_W-1:0]  cmd_tmo;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              bus_wr_en;
  logic              bus_rd_en;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, cmd_tmo,
    input  rsp_ready, bus_rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output bus_wr_en, bus_rd_en, bus_addr, bus_wdata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, cmd_tmo,
    output rsp_ready, bus_rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  bus_wr_en, bus_rd_en, bus_addr, bus_wdata
  );
endinterface

// File: rtl/reg_bus_master_ctrl.sv
// Command-driven register bus initiator. Accepts write / read / poll
// commands, issues single-cycle bus strobes and returns read data plus an
// error flag. Poll re-reads one address every POLL_GAP+1 cycles until the
// masked compare matches or cmd_tmo+1 reads have been made.
module reg_bus_master_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int TMO_W    = 8,
  parameter int POLL_GAP = 4
) (
  input logic                clk,
  input logic                rst_n,
  reg_bus_master_ctrl_if.master rb
);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(POLL_GAP - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WRITE     = 3'd1;
  localparam logic [2:0] READ      = 3'd2;
  localparam logic [2:0] POLL_RD   = 3'd3;
  localparam logic [2:0] POLL_WAIT = 3'd4;
  localparam logic [2:0] RESP      = 3'd5;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;

  // Masked equality used to terminate a poll; a zero mask always matches.
  function automatic logic poll_match(
    input logic [DATA_W-1:0] data,
    input logic [DATA_W-1:0] expect_val,
    input logic [DATA_W-1:0] mask
  );
    return ((data & mask) == (expect_val & mask));
  endfunction

  logic [2:0]        state_r,   state_nxt_s;
  logic [ADDR_W-1:0] addr_r,    addr_nxt_s;
  logic [DATA_W-1:0] wdata_r,   wdata_nxt_s;
  logic [DATA_W-1:0] mask_r,    mask_nxt_s;
  logic [TMO_W-1:0]  tmo_r,     tmo_nxt_s;
  logic [TMO_W-1:0]  attempt_r, attempt_nxt_s;
  logic [GAP_W-1:0]  gap_r,     gap_nxt_s;
  logic [DATA_W-1:0] rdata_r,   rdata_nxt_s;
  logic              err_r,     err_nxt_s;

  logic cmd_ready_r;
  logic rsp_valid_r;
  logic wr_en_r;
  logic rd_en_r;

  // Next-state and datapath decode for the command sequencer.
  always_comb begin
    state_nxt_s   = state_r;
    addr_nxt_s    = addr_r;
    wdata_nxt_s   = wdata_r;
    mask_nxt_s    = mask_r;
    tmo_nxt_s     = tmo_r;
    attempt_nxt_s = attempt_r;
    gap_nxt_s     = gap_r;
    rdata_nxt_s   = rdata_r;
    err_nxt_s     = err_r;
    case (state_r)
      IDLE: begin
        if (rb.cmd_valid) begin
          addr_nxt_s    = rb.cmd_addr;
          wdata_nxt_s   = rb.cmd_wdata;
          mask_nxt_s    = rb.cmd_mask;
          tmo_nxt_s     = rb.cmd_tmo;
          attempt_nxt_s = '0;
          case (rb.cmd_op)
            OP_WRITE: state_nxt_s = WRITE;
            OP_READ:  state_nxt_s = READ;
            OP_POLL:  state_nxt_s = POLL_RD;
            default: begin
              // Reserved op: answer with an error and never touch the bus.
              state_nxt_s = RESP;
              rdata_nxt_s = '0;
              err_nxt_s   = 1'b1;
            end
          endcase
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        rdata_nxt_s = '0;
        err_nxt_s   = 1'b0;
        state_nxt_s = RESP;
      end
      READ: begin
        rdata_nxt_s = rb.bus_rdata;
        err_nxt_s   = 1'b0;
        state_nxt_s = RESP;
      end
      POLL_RD: begin
        rdata_nxt_s = rb.bus_rdata;
        // Match outranks timeout so the final permitted read can still succeed.
        if (poll_match(rb.bus_rdata, wdata_r, mask_r)) begin
          err_nxt_s   = 1'b0;
          state_nxt_s = RESP;
        end else if (attempt_r == tmo_r) begin
          err_nxt_s   = 1'b1;
          state_nxt_s = RESP;
        end else begin
          attempt_nxt_s = attempt_r + TMO_W'(1);
          gap_nxt_s     = GAP_LOAD;
          state_nxt_s   = POLL_WAIT;
        end
      end
      POLL_WAIT: begin
        if (gap_r == '0) begin
          state_nxt_s = POLL_RD;
        end else begin
          gap_nxt_s = gap_r - GAP_W'(1);
        end
      end
      RESP: begin
        if (rb.rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, latched command fields and registered outputs; output flops
  // decode the next state so they always equal a decode of state_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      addr_r      <= '0;
      wdata_r     <= '0;
      mask_r      <= '0;
      tmo_r       <= '0;
      attempt_r   <= '0;
      gap_r       <= '0;
      rdata_r     <= '0;
      err_r       <= 1'b0;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      wr_en_r     <= 1'b0;
      rd_en_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      addr_r      <= addr_nxt_s;
      wdata_r     <= wdata_nxt_s;
      mask_r      <= mask_nxt_s;
      tmo_r       <= tmo_nxt_s;
      attempt_r   <= attempt_nxt_s;
      gap_r       <= gap_nxt_s;
      rdata_r     <= rdata_nxt_s;
      err_r       <= err_nxt_s;
      cmd_ready_r <= (state_nxt_s == IDLE);
      rsp_valid_r <= (state_nxt_s == RESP);
      wr_en_r     <= (state_nxt_s == WRITE);
      rd_en_r     <= (state_nxt_s == READ) || (state_nxt_s == POLL_RD);
    end
  end

  assign rb.cmd_ready = cmd_ready_r;
  assign rb.rsp_valid = rsp_valid_r;
  assign rb.rsp_rdata = rdata_r;
  assign rb.rsp_err   = err_r;
  assign rb.bus_wr_en = wr_en_r;
  assign rb.bus_rd_en = rd_en_r;
  assign rb.bus_addr  = addr_r;
  assign rb.bus_wdata = wdata_r;

endmodule
